// File: rtl/shift_left_serial.sv
// Multi-cycle SLL/ROL unit: accepts one request, shifts left one bit per clock, holds result until consumed.
// Optional macro SHIFT_LEFT_FAST2_EN: shift two bits per clock while at least two remain.
module shift_left_serial #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic             Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data, nxt_data;
  logic [CNT_W-1:0] rem, nxt_rem;
  logic             op;

  // Next shift step; only meaningful in SHIFT where rem is non-zero.
  always_comb begin
    nxt_data = data;
    nxt_rem  = rem;
    if (rem != '0) begin
`ifdef SHIFT_LEFT_FAST2_EN
      if (rem >= CNT_W'(2)) begin
        nxt_data = op ? {data[WIDTH-3:0], data[WIDTH-1:WIDTH-2]} : {data[WIDTH-3:0], 2'b00};
        nxt_rem  = rem - CNT_W'(2);
      end else begin
        nxt_data = {data[WIDTH-2:0], op & data[WIDTH-1]};
        nxt_rem  = rem - CNT_W'(1);
      end
`else
      nxt_data = {data[WIDTH-2:0], op & data[WIDTH-1]};
      nxt_rem  = rem - CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      rem   <= '0;
      op    <= 1'b0;
      Out   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data <= In;
          op   <= Op;
          if (Cnt == '0) begin
            Out   <= In;
            state <= DONE;
          end else begin
            rem   <= Cnt;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          data <= nxt_data;
          rem  <= nxt_rem;
          if (nxt_rem == '0) begin
            Out   <= nxt_data;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
